// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the RV32I fetch stage: next-PC select codes,
// default boot PC and bubble instruction, and the fetch FSM encoding.
package fetch_stage_pkg;

   localparam logic [1:0] PCSEL_REFETCH = 2'b00;
   localparam logic [1:0] PCSEL_ALU     = 2'b01;
   localparam logic [1:0] PCSEL_PLUS4   = 2'b10;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_2000;
   localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } fetch_state_e;

   function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_perf_counters.sv
// Fetch/bubble performance counters; one of the two advances on each enabled
// cycle depending on whether a valid instruction entered the pipeline.
module fetch_perf_counters
   import fetch_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        fetch_valid,
   output logic [31:0] fetch_count,
   output logic [31:0] bubble_count
);

   logic [31:0] fetch_q;
   logic [31:0] bubble_q;

   // Both counters wrap silently modulo 2^32.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_q  <= '0;
         bubble_q <= '0;
      end else if (en) begin
         if (fetch_valid) begin
            fetch_q <= fetch_q + 32'd1;
         end else begin
            bubble_q <= bubble_q + 32'd1;
         end
      end
   end

   assign fetch_count  = fetch_q;
   assign bubble_count = bubble_q;

endmodule

// File: rtl/fetch_stage.sv
// PC generation and fetch pipeline register for the 3-stage RV32I core,
// including bubble insertion on redirects/boot and stall hold.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         stall,
   input  logic [1:0]   pc_sel,
   input  logic [31:0]  alu_target,
   output logic [31:0]  icache_addr,
   output logic         icache_re,
   input  logic [31:0]  icache_dout,
   output logic [31:0]  fetch_pc,
   output logic [31:0]  prev_inst,
   output logic [31:0]  prev_pc,
   output logic [31:0]  fetch_count,
   output logic [31:0]  bubble_count,
   output fetch_state_e fsm_state
);

   fetch_state_e state;
   fetch_state_e next_state;
   logic         fetch_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= BOOT;
      end else begin
         state <= next_state;
      end
   end

   // Stalling re-presents fetch_pc so the synchronous read keeps dout valid.
   always_comb begin
      next_state  = state;
      fetch_valid = 1'b0;
      icache_addr = fetch_pc;
      if (!stall) begin
         if (state == BOOT) begin
            icache_addr = pc_plus4(RESET_PC);
            next_state  = RUN;
         end else begin
            fetch_valid = pc_sel[1];
            case (pc_sel)
               PCSEL_REFETCH: icache_addr = pc_plus4(prev_pc);
               PCSEL_ALU:     icache_addr = alu_target;
               default:       icache_addr = pc_plus4(fetch_pc);
            endcase
         end
      end
      if (!rst_n) begin
         icache_addr = RESET_PC;
      end
   end

   // A redirect or refetch means the word on dout is wrong-path: squash it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc  <= RESET_PC;
         prev_pc   <= RESET_PC;
         prev_inst <= NOP_INST;
      end else if (!stall) begin
         fetch_pc  <= icache_addr;
         prev_pc   <= fetch_pc;
         prev_inst <= fetch_valid ? icache_dout : NOP_INST;
      end
   end

   fetch_perf_counters u_perf (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (!stall),
      .fetch_valid  (fetch_valid),
      .fetch_count  (fetch_count),
      .bubble_count (bubble_count)
   );

   assign icache_re = 1'b1;
   assign fsm_state = state;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: boot, redirect, refetch, stall, mid-run reset
// and 32-bit wrap, against a synchronous icache model whose words encode the address.
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic         clk;
   logic         rst_n;
   logic         stall;
   logic [1:0]   pc_sel;
   logic [31:0]  alu_target;
   logic [31:0]  icache_addr;
   logic         icache_re;
   logic [31:0]  icache_dout;
   logic [31:0]  fetch_pc;
   logic [31:0]  prev_inst;
   logic [31:0]  prev_pc;
   logic [31:0]  fetch_count;
   logic [31:0]  bubble_count;
   fetch_state_e fsm_state;

   int n_checks = 0;
   int n_fail   = 0;

   fetch_stage dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall        (stall),
      .pc_sel       (pc_sel),
      .alu_target   (alu_target),
      .icache_addr  (icache_addr),
      .icache_re    (icache_re),
      .icache_dout  (icache_dout),
      .fetch_pc     (fetch_pc),
      .prev_inst    (prev_inst),
      .prev_pc      (prev_pc),
      .fetch_count  (fetch_count),
      .bubble_count (bubble_count),
      .fsm_state    (fsm_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // icache model: word at address A is {16'hC0DE, A[15:0]}, one-cycle read
   function automatic logic [31:0] word_at(input logic [31:0] a);
      return {16'hC0DE, a[15:0]};
   endfunction

   initial icache_dout = 32'h0;
   always @(posedge clk) icache_dout <= word_at(icache_addr);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_regs(input string tag, input logic [31:0] fpc, input logic [31:0] ppc,
                             input logic [31:0] pinst, input logic [31:0] fc, input logic [31:0] bc);
      check({tag, ".fetch_pc"}, fetch_pc, fpc);
      check({tag, ".prev_pc"}, prev_pc, ppc);
      check({tag, ".prev_inst"}, prev_inst, pinst);
      check({tag, ".fetch_count"}, fetch_count, fc);
      check({tag, ".bubble_count"}, bubble_count, bc);
   endtask

   // driver: advance one cycle, return at the falling edge
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic [1:0] sel, input logic [31:0] tgt);
      pc_sel     = sel;
      alu_target = tgt;
      #1;
   endtask

   initial begin
      rst_n      = 1'b0;
      stall      = 1'b0;
      pc_sel     = 2'b10;
      alu_target = 32'h0;
      repeat (2) @(negedge clk);

      // reset state
      check_regs("rst", 32'h2000, 32'h2000, NOP, 32'h0, 32'h0);
      check("rst.icache_addr", icache_addr, 32'h2000);
      check("rst.icache_re", {31'b0, icache_re}, 32'h1);
      check("rst.state", {31'b0, fsm_state}, 32'h0);

      // boot: BOOT cycle presents RESET_PC+4 and bubbles
      rst_n = 1'b1;
      #1;
      check("boot.icache_addr", icache_addr, 32'h2004);
      step();
      check_regs("boot1", 32'h2004, 32'h2000, NOP, 32'h0, 32'h1);
      check("boot1.state", {31'b0, fsm_state}, 32'h1);
      check("boot1.icache_addr", icache_addr, 32'h2008);
      step();
      check_regs("run1", 32'h2008, 32'h2004, 32'hC0DE2004, 32'h1, 32'h1);
      step();
      step();
      check_regs("run3", 32'h2010, 32'h200C, 32'hC0DE200C, 32'h3, 32'h1);

      // redirect to 0x2100
      drive(2'b01, 32'h2100);
      check("redir.icache_addr", icache_addr, 32'h2100);
      step();
      check_regs("redir1", 32'h2100, 32'h2010, NOP, 32'h3, 32'h2);
      drive(2'b10, 32'h0);
      check("redir1.icache_addr", icache_addr, 32'h2104);
      step();
      check_regs("redir2", 32'h2104, 32'h2100, 32'hC0DE2100, 32'h4, 32'h2);

      // get prev_pc to 0x2008, then refetch
      drive(2'b01, 32'h2004);
      step();
      check_regs("redir3", 32'h2004, 32'h2104, NOP, 32'h4, 32'h3);
      drive(2'b10, 32'h0);
      step();
      step();
      check_regs("pre_refetch", 32'h200C, 32'h2008, 32'hC0DE2008, 32'h6, 32'h3);
      drive(2'b00, 32'h0);
      check("refetch.icache_addr", icache_addr, 32'h200C);
      step();
      check_regs("refetch", 32'h200C, 32'h200C, NOP, 32'h6, 32'h4);
      drive(2'b10, 32'h0);
      check("post_refetch.icache_addr", icache_addr, 32'h2010);
      step();
      check_regs("post_refetch", 32'h2010, 32'h200C, 32'hC0DE200C, 32'h7, 32'h4);

      // stall with a pending redirect: everything holds
      stall = 1'b1;
      drive(2'b01, 32'h2200);
      check("stall0.icache_addr", icache_addr, 32'h2010);
      for (int i = 0; i < 3; i++) begin
         step();
         check_regs("stall", 32'h2010, 32'h200C, 32'hC0DE200C, 32'h7, 32'h4);
         check("stall.icache_addr", icache_addr, 32'h2010);
      end
      stall = 1'b0;
      #1;
      check("unstall.icache_addr", icache_addr, 32'h2200);
      step();
      check_regs("unstall", 32'h2200, 32'h2010, NOP, 32'h7, 32'h5);

      // move to 0x2040, then reset mid-stream
      drive(2'b01, 32'h2040);
      step();
      check_regs("to2040", 32'h2040, 32'h2200, NOP, 32'h7, 32'h6);
      drive(2'b10, 32'h0);
      rst_n = 1'b0;
      #1;
      check_regs("midrst", 32'h2000, 32'h2000, NOP, 32'h0, 32'h0);
      check("midrst.icache_addr", icache_addr, 32'h2000);
      check("midrst.state", {31'b0, fsm_state}, 32'h0);
      step();
      rst_n = 1'b1;
      #1;
      check("reboot.icache_addr", icache_addr, 32'h2004);
      step();
      check_regs("reboot1", 32'h2004, 32'h2000, NOP, 32'h0, 32'h1);

      // wrap at the top of the address space and of fetch_count
      drive(2'b01, 32'hFFFF_FFFC);
      step();
      check_regs("to_top", 32'hFFFF_FFFC, 32'h2004, NOP, 32'h0, 32'h2);
      drive(2'b10, 32'h0);
      check("wrap.icache_addr", icache_addr, 32'h0000_0000);
      force dut.u_perf.fetch_q = 32'hFFFF_FFFF;
      #1;
      release dut.u_perf.fetch_q;
      #1;
      check("preload.fetch_count", fetch_count, 32'hFFFF_FFFF);
      step();
      check_regs("wrap", 32'h0000_0000, 32'hFFFF_FFFC, 32'hC0DEFFFC, 32'h0, 32'h2);

      // reserved select behaves as +4
      drive(2'b11, 32'h1234_5678);
      check("sel11.icache_addr", icache_addr, 32'h0000_0004);
      step();
      check_regs("sel11", 32'h0000_0004, 32'h0000_0000, 32'hC0DE0000, 32'h1, 32'h2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
